lenet_sequencer: RTL and testbench
==================================

LENET_SEQUENCER -- requirements
Module: lenet_sequencer

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- VSYNC_ACTIVE, 1'b0, vsync asserted level.
- BOUND_FRAMES, 60, frames the bounding box shows before capture (>=1).
- HOLD_FRAMES, 120, frames the result is displayed (>=1).
- TIMEOUT_CYCLES, 2000000, max clk24 cycles waiting for lenet_ready (>=1).
REQ-002 clk24  in  1  single clock for all logic.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 capture_req  in  1  single-cycle request to start a recognition sequence.
REQ-005 abort  in  1  single-cycle request to return to live view.
REQ-006 vga_vsync  in  1  vsync from the VGA timing block, clk24 domain.
REQ-007 lenet_ready  in  1  single-cycle pulse: CNN result valid.
REQ-008 lenet_digit  in  4  CNN result, valid with lenet_ready.
REQ-009 bound_doing  out  1  VGA draws the capture box.
REQ-010 lenet_doing  out  1  VGA draws the seven-segment result.
REQ-011 capture_en  out  1  CNN input buffer samples the frame.
REQ-012 lenet_start  out  1  single-cycle CNN start pulse.
REQ-013 digit_out  out  4  latched result; 4'hF means none or timeout.
REQ-014 busy  out  1  high in every state except IDLE.

Function
REQ-015 frame_tick SHALL be a one-cycle pulse on vga_vsync going from ~VSYNC_ACTIVE to VSYNC_ACTIVE, detected with one register stage.
REQ-016 The FSM SHALL have states IDLE, BOUND, CAPTURE, START, WAIT, SHOW; all outputs SHALL be registered.
REQ-017 IDLE: capture_req -> BOUND, with bound_doing=1 on the next cycle; the frame counter clears.
REQ-018 BOUND: count frame_ticks; the BOUND_FRAMES-th tick -> CAPTURE, with capture_en=1 from the next cycle.
REQ-019 CAPTURE: capture_en stays 1 until the next frame_tick, then drops the following cycle; the state goes to START; bound_doing stays 1 throughout CAPTURE.
REQ-020 START: lenet_start=1 for exactly one cycle, bound_doing drops, and the state goes to WAIT with the timeout counter cleared.
REQ-021 WAIT: lenet_ready -> latch lenet_digit into digit_out and go to SHOW; reaching TIMEOUT_CYCLES -> digit_out=4'hF and go to SHOW; if both happen in the same cycle, lenet_ready wins.
REQ-022 SHOW: lenet_doing=1; count HOLD_FRAMES frame_ticks, then go to IDLE and set lenet_doing=0; digit_out is held.
REQ-023 Ignored inputs:
- capture_req outside IDLE.
- lenet_ready outside WAIT.
REQ-024 abort in any state -> IDLE next cycle; bound_doing, lenet_doing, capture_en and lenet_start go to 0; digit_out is unchanged. abort wins over a simultaneous capture_req or lenet_ready.
REQ-025 Counter widths: frame counter $clog2(max(BOUND_FRAMES,HOLD_FRAMES)+1); timeout counter $clog2(TIMEOUT_CYCLES+1); neither counter wraps.
REQ-026 busy SHALL equal (state != IDLE), registered with the state.

Reset
REQ-027 rst SHALL force:
- state IDLE; counters 0; edge register ~VSYNC_ACTIVE.
- bound_doing, lenet_doing, capture_en, lenet_start, busy all 0.
- digit_out 4'hF.
REQ-028 rst asserted mid-sequence SHALL abandon the sequence immediately (asynchronous); after release, no lenet_start is issued without a new capture_req.

Structure
REQ-029 Package lenet_seq_pkg SHALL hold:
- the state enum typedef;
- the DIGIT_NONE=4'hF constant;
- the default parameter constants.
REQ-030 The block is a single module with no sub-module; the frame_tick edge detector is inline.

Verification (BOUND_FRAMES=2, HOLD_FRAMES=3, TIMEOUT_CYCLES=100)
REQ-031 capture_req in IDLE -> bound_doing=1 next cycle. After 2 ticks capture_en is high for one frame. Then one lenet_start pulse. lenet_ready with digit 7 -> digit_out=7 and lenet_doing=1 for 3 frames, then IDLE with busy=0.
REQ-032 No lenet_ready -> after 100 WAIT cycles digit_out=4'hF and lenet_doing=1.
REQ-033 lenet_ready with digit 3 on the timeout cycle -> digit_out=3.
REQ-034 abort during CAPTURE -> capture_en=0 and state IDLE next cycle, no lenet_start. capture_req during SHOW -> ignored.
REQ-035 rst pulsed during WAIT -> all outputs at reset values. A later lenet_ready -> digit_out stays 4'hF.

Source files
------------

// File: rtl/lenet_seq_pkg.sv
// ----------------------------------------------------------------------------
// lenet_seq_pkg
// Shared definitions for the LeNet capture/recognise/display sequencer:
//   - seq_state_e : sequencer state encoding
//   - DIGIT_NONE  : digit_out value meaning "no result" (reset or timeout)
//   - DEF_*       : default values for the lenet_sequencer parameters
// ----------------------------------------------------------------------------
package lenet_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_BOUND   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_START   = 3'd3,
        ST_WAIT    = 3'd4,
        ST_SHOW    = 3'd5
    } seq_state_e;

    localparam logic [3:0] DIGIT_NONE = 4'hF;

    localparam logic DEF_VSYNC_ACTIVE   = 1'b0;
    localparam int   DEF_BOUND_FRAMES   = 60;
    localparam int   DEF_HOLD_FRAMES    = 120;
    localparam int   DEF_TIMEOUT_CYCLES = 2000000;

endpackage

// File: rtl/lenet_sequencer.sv
// ----------------------------------------------------------------------------
// lenet_sequencer
// Sequences one digit-recognition pass: show the capture box for a number of
// frames, let the CNN input buffer sample one frame, kick the CNN, wait for
// its result (with a timeout) and display the result for a number of frames.
//
// Ports (all in the clk24 domain):
//   clk24        in   clock
//   rst          in   asynchronous active-high reset
//   capture_req  in   pulse: start a sequence (honoured only when idle)
//   abort        in   pulse: drop back to live view from any state
//   vga_vsync    in   vsync from the VGA timing block
//   lenet_ready  in   pulse: CNN result valid (honoured only while waiting)
//   lenet_digit  in   CNN result, valid with lenet_ready
//   bound_doing  out  VGA draws the capture box
//   lenet_doing  out  VGA draws the seven-segment result
//   capture_en   out  CNN input buffer samples the current frame
//   lenet_start  out  one-cycle CNN start pulse
//   digit_out    out  latched result, DIGIT_NONE when none or timed out
//   busy         out  high whenever the sequencer is not idle
// ----------------------------------------------------------------------------
module lenet_sequencer
    import lenet_seq_pkg::*;
#(
    parameter logic VSYNC_ACTIVE   = DEF_VSYNC_ACTIVE,
    parameter int   BOUND_FRAMES   = DEF_BOUND_FRAMES,
    parameter int   HOLD_FRAMES    = DEF_HOLD_FRAMES,
    parameter int   TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       clk24,
    input  logic       rst,
    input  logic       capture_req,
    input  logic       abort,
    input  logic       vga_vsync,
    input  logic       lenet_ready,
    input  logic [3:0] lenet_digit,
    output logic       bound_doing,
    output logic       lenet_doing,
    output logic       capture_en,
    output logic       lenet_start,
    output logic [3:0] digit_out,
    output logic       busy
);

    localparam int FRAME_MAX = (BOUND_FRAMES > HOLD_FRAMES) ? BOUND_FRAMES : HOLD_FRAMES;
    localparam int FRAME_W   = $clog2(FRAME_MAX + 1);
    localparam int TO_W      = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [FRAME_W-1:0] BOUND_LAST = FRAME_W'(BOUND_FRAMES - 1);
    localparam logic [FRAME_W-1:0] HOLD_LAST  = FRAME_W'(HOLD_FRAMES - 1);
    localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);

    seq_state_e         state_r;
    seq_state_e         state_s;
    logic [FRAME_W-1:0] frame_cnt_r;
    logic [FRAME_W-1:0] frame_cnt_s;
    logic [TO_W-1:0]    to_cnt_r;
    logic [TO_W-1:0]    to_cnt_s;
    logic               vsync_r;
    logic               frame_tick_s;
    logic [3:0]         digit_s;
    logic               bound_doing_s;
    logic               lenet_doing_s;
    logic               capture_en_s;
    logic               lenet_start_s;
    logic               busy_s;

    // Frame start: vsync has just moved into its asserted level.
    assign frame_tick_s = (vga_vsync == VSYNC_ACTIVE) && (vsync_r != VSYNC_ACTIVE);

    // Next-state, counter and output decode; outputs follow the next state so
    // that, once registered, they line up exactly with the state register.
    always_comb begin
        state_s     = state_r;
        frame_cnt_s = frame_cnt_r;
        to_cnt_s    = to_cnt_r;
        digit_s     = digit_out;

        if (abort) begin
            state_s     = ST_IDLE;
            frame_cnt_s = '0;
            to_cnt_s    = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (capture_req) begin
                        state_s     = ST_BOUND;
                        frame_cnt_s = '0;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_BOUND: begin
                    if (frame_tick_s && (frame_cnt_r == BOUND_LAST)) begin
                        state_s     = ST_CAPTURE;
                        frame_cnt_s = '0;
                    end else if (frame_tick_s) begin
                        frame_cnt_s = frame_cnt_r + FRAME_W'(1);
                    end else begin
                        frame_cnt_s = frame_cnt_r;
                    end
                end
                ST_CAPTURE: begin
                    // The buffer samples exactly one whole frame.
                    if (frame_tick_s) begin
                        state_s = ST_START;
                    end else begin
                        state_s = ST_CAPTURE;
                    end
                end
                ST_START: begin
                    state_s  = ST_WAIT;
                    to_cnt_s = '0;
                end
                ST_WAIT: begin
                    // A result arriving on the timeout cycle still counts.
                    if (lenet_ready) begin
                        digit_s     = lenet_digit;
                        state_s     = ST_SHOW;
                        frame_cnt_s = '0;
                    end else if (to_cnt_r == TO_LAST) begin
                        digit_s     = DIGIT_NONE;
                        state_s     = ST_SHOW;
                        frame_cnt_s = '0;
                    end else begin
                        to_cnt_s = to_cnt_r + TO_W'(1);
                    end
                end
                ST_SHOW: begin
                    if (frame_tick_s && (frame_cnt_r == HOLD_LAST)) begin
                        state_s     = ST_IDLE;
                        frame_cnt_s = '0;
                    end else if (frame_tick_s) begin
                        frame_cnt_s = frame_cnt_r + FRAME_W'(1);
                    end else begin
                        frame_cnt_s = frame_cnt_r;
                    end
                end
                default: begin
                    state_s     = ST_IDLE;
                    frame_cnt_s = '0;
                    to_cnt_s    = '0;
                end
            endcase
        end

        bound_doing_s = (state_s == ST_BOUND) || (state_s == ST_CAPTURE);
        capture_en_s  = (state_s == ST_CAPTURE);
        lenet_start_s = (state_s == ST_START);
        lenet_doing_s = (state_s == ST_SHOW);
        busy_s        = (state_s != ST_IDLE);
    end

    // State, counters, vsync history and all outputs.
    always_ff @(posedge clk24 or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            frame_cnt_r <= '0;
            to_cnt_r    <= '0;
            vsync_r     <= ~VSYNC_ACTIVE;
            bound_doing <= 1'b0;
            lenet_doing <= 1'b0;
            capture_en  <= 1'b0;
            lenet_start <= 1'b0;
            busy        <= 1'b0;
            digit_out   <= DIGIT_NONE;
        end else begin
            state_r     <= state_s;
            frame_cnt_r <= frame_cnt_s;
            to_cnt_r    <= to_cnt_s;
            vsync_r     <= vga_vsync;
            bound_doing <= bound_doing_s;
            lenet_doing <= lenet_doing_s;
            capture_en  <= capture_en_s;
            lenet_start <= lenet_start_s;
            busy        <= busy_s;
            digit_out   <= digit_s;
        end
    end

endmodule

// File: tb/tb_lenet_sequencer.sv
// ----------------------------------------------------------------------------
// tb_lenet_sequencer
// Self-checking bench for lenet_sequencer with BOUND_FRAMES=2, HOLD_FRAMES=3,
// TIMEOUT_CYCLES=100 and active-low vsync. A table drives the main flow,
// hand-written sequences cover timeout, abort and reset corners, and a random
// phase is compared every cycle against a phase-level reference model.
// ----------------------------------------------------------------------------
module tb_lenet_sequencer;

    localparam int BF = 2;
    localparam int HF = 3;
    localparam int TO = 100;

    logic       clk24 = 1'b0;
    logic       rst;
    logic       capture_req;
    logic       abort;
    logic       vga_vsync;
    logic       lenet_ready;
    logic [3:0] lenet_digit;
    logic       bound_doing;
    logic       lenet_doing;
    logic       capture_en;
    logic       lenet_start;
    logic [3:0] digit_out;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    lenet_sequencer #(
        .VSYNC_ACTIVE   (1'b0),
        .BOUND_FRAMES   (BF),
        .HOLD_FRAMES    (HF),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk24       (clk24),
        .rst         (rst),
        .capture_req (capture_req),
        .abort       (abort),
        .vga_vsync   (vga_vsync),
        .lenet_ready (lenet_ready),
        .lenet_digit (lenet_digit),
        .bound_doing (bound_doing),
        .lenet_doing (lenet_doing),
        .capture_en  (capture_en),
        .lenet_start (lenet_start),
        .digit_out   (digit_out),
        .busy        (busy)
    );

    always #5 clk24 = ~clk24;

    // Table vector: inputs for one cycle, then {bd,ld,ce,ls,busy,digit} after it.
    typedef struct {
        logic       req;
        logic       ab;
        logic       vs;
        logic       rdy;
        logic [3:0] dig;
        logic [8:0] want;
    } vec_t;
    vec_t tbl[15];

    // Reference model: which phase of the sequence we are in, plus event counts.
    typedef enum int {P_IDLE, P_BOUND, P_CAPTURE, P_START, P_WAIT, P_SHOW} phase_e;
    phase_e     m_phase;
    int         m_ticks;
    int         m_waits;
    logic [3:0] m_digit;
    logic       m_vs_prev;

    function automatic logic [8:0] model_out();
        logic bd = (m_phase == P_BOUND) || (m_phase == P_CAPTURE);
        return {bd, m_phase == P_SHOW, m_phase == P_CAPTURE, m_phase == P_START,
                m_phase != P_IDLE, m_digit};
    endfunction

    function automatic logic [8:0] dut_out();
        return {bound_doing, lenet_doing, capture_en, lenet_start, busy, digit_out};
    endfunction

    task automatic model_reset();
        m_phase   = P_IDLE;
        m_ticks   = 0;
        m_waits   = 0;
        m_digit   = 4'hF;
        m_vs_prev = 1'b1;
    endtask

    task automatic model_step(input logic req, input logic ab, input logic vs,
                              input logic rdy, input logic [3:0] dig);
        logic tick = (vs == 1'b0) && (m_vs_prev == 1'b1);
        m_vs_prev = vs;
        if (ab) begin
            m_phase = P_IDLE;
        end else begin
            case (m_phase)
                P_IDLE:    if (req) begin m_phase = P_BOUND; m_ticks = 0; end
                P_BOUND:   if (tick) begin
                               m_ticks++;
                               if (m_ticks == BF) m_phase = P_CAPTURE;
                           end
                P_CAPTURE: if (tick) m_phase = P_START;
                P_START:   begin m_phase = P_WAIT; m_waits = 0; end
                P_WAIT:    begin
                               m_waits++;
                               if (rdy) begin
                                   m_digit = dig; m_phase = P_SHOW; m_ticks = 0;
                               end else if (m_waits == TO) begin
                                   m_digit = 4'hF; m_phase = P_SHOW; m_ticks = 0;
                               end
                           end
                P_SHOW:    if (tick) begin
                               m_ticks++;
                               if (m_ticks == HF) m_phase = P_IDLE;
                           end
                default:   m_phase = P_IDLE;
            endcase
        end
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    task automatic drive(input logic req, input logic ab, input logic vs,
                         input logic rdy, input logic [3:0] dig);
        capture_req = req;
        abort       = ab;
        vga_vsync   = vs;
        lenet_ready = rdy;
        lenet_digit = dig;
        model_step(req, ab, vs, rdy, dig);
        @(posedge clk24);
        @(negedge clk24);
    endtask

    // One cycle, checked against the reference model.
    task automatic cycle(input logic req, input logic ab, input logic vs,
                         input logic rdy, input logic [3:0] dig);
        drive(req, ab, vs, rdy, dig);
        check("model", 16'(dut_out()), 16'(model_out()));
    endtask

    // From IDLE: request, two bound frames, one capture frame, START, then WAIT.
    task automatic run_to_wait();
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    endtask

    function automatic vec_t mk(input logic req, input logic vs, input logic rdy,
                                input logic [3:0] dig, input logic [8:0] want);
        vec_t v;
        v.req = req; v.ab = 1'b0; v.vs = vs; v.rdy = rdy; v.dig = dig; v.want = want;
        return v;
    endfunction

    // Watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw_start;
        logic vs_rand;

        //            req   vs    rdy   dig    {bd,ld,ce,ls,busy,digit}
        tbl[0]  = mk(1'b1, 1'b1, 1'b0, 4'd0, 9'b1_0_0_0_1_1111);
        tbl[1]  = mk(1'b0, 1'b0, 1'b0, 4'd0, 9'b1_0_0_0_1_1111);
        tbl[2]  = mk(1'b0, 1'b1, 1'b0, 4'd0, 9'b1_0_0_0_1_1111);
        tbl[3]  = mk(1'b0, 1'b0, 1'b0, 4'd0, 9'b1_0_1_0_1_1111);
        tbl[4]  = mk(1'b0, 1'b1, 1'b0, 4'd0, 9'b1_0_1_0_1_1111);
        tbl[5]  = mk(1'b0, 1'b0, 1'b0, 4'd0, 9'b0_0_0_1_1_1111);
        tbl[6]  = mk(1'b0, 1'b0, 1'b0, 4'd0, 9'b0_0_0_0_1_1111);
        tbl[7]  = mk(1'b0, 1'b0, 1'b1, 4'd7, 9'b0_1_0_0_1_0111);
        tbl[8]  = mk(1'b0, 1'b1, 1'b0, 4'd0, 9'b0_1_0_0_1_0111);
        tbl[9]  = mk(1'b0, 1'b0, 1'b0, 4'd0, 9'b0_1_0_0_1_0111);
        tbl[10] = mk(1'b0, 1'b1, 1'b0, 4'd0, 9'b0_1_0_0_1_0111);
        tbl[11] = mk(1'b0, 1'b0, 1'b0, 4'd0, 9'b0_1_0_0_1_0111);
        tbl[12] = mk(1'b1, 1'b1, 1'b0, 4'd0, 9'b0_1_0_0_1_0111);
        tbl[13] = mk(1'b0, 1'b0, 1'b0, 4'd0, 9'b0_0_0_0_0_0111);
        tbl[14] = mk(1'b0, 1'b1, 1'b1, 4'd5, 9'b0_0_0_0_0_0111);

        rst = 1'b1; capture_req = 1'b0; abort = 1'b0;
        vga_vsync = 1'b1; lenet_ready = 1'b0; lenet_digit = 4'd0;
        model_reset();
        repeat (3) @(negedge clk24);
        check("reset_state", 16'(dut_out()), 16'(9'b0_0_0_0_0_1111));
        rst = 1'b0;

        // Main flow: box, capture, start, result 7, show, back to idle.
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].req, tbl[i].ab, tbl[i].vs, tbl[i].rdy, tbl[i].dig);
            check($sformatf("table[%0d]", i), 16'(dut_out()), 16'(tbl[i].want));
        end

        // Timeout: still waiting after 99 cycles, result NONE on the 100th.
        run_to_wait();
        repeat (TO - 1) cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        check("timeout_pre", {10'd0, lenet_doing, busy, digit_out}, {10'd0, 1'b0, 1'b1, 4'h7});
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        check("timeout_hit", {10'd0, lenet_doing, busy, digit_out}, {10'd0, 1'b1, 1'b1, 4'hF});

        // Abort from SHOW, then abort during CAPTURE: no start pulse follows.
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        check("abort_show", {11'd0, lenet_doing, busy, 3'd0}, 16'd0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        check("capture_on", {15'd0, capture_en}, 16'd1);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        check("abort_capture", {13'd0, capture_en, busy, bound_doing}, 16'd0);
        saw_start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 1'b0, 1'(i % 2), 1'b0, 4'd0);
            saw_start = saw_start | lenet_start;
        end
        check("no_start_after_abort", {15'd0, saw_start}, 16'd0);

        // lenet_ready on the very cycle the timeout is reached wins.
        run_to_wait();
        repeat (TO - 1) cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'd3);
        check("ready_on_timeout", {11'd0, lenet_doing, digit_out}, {11'd0, 1'b1, 4'd3});

        // capture_req during SHOW is ignored: still showing 3 afterwards.
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        check("req_in_show", {10'd0, bound_doing, lenet_doing, digit_out}, {10'd0, 1'b0, 1'b1, 4'd3});
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);

        // Asynchronous reset in WAIT, then a stray lenet_ready.
        run_to_wait();
        repeat (5) cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        #2 rst = 1'b1;
        #1 check("async_reset", 16'(dut_out()), 16'(9'b0_0_0_0_0_1111));
        model_reset();
        @(negedge clk24);
        rst = 1'b0;
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'd9);
        check("ready_after_reset", {12'd0, digit_out}, 16'hF);
        saw_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, 1'(i % 2), 1'b0, 4'd0);
            saw_start = saw_start | lenet_start;
        end
        check("no_start_after_reset", {15'd0, saw_start}, 16'd0);

        // Random traffic against the reference model.
        vs_rand = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) vs_rand = ~vs_rand;
            cycle(($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 63) == 0),
                  vs_rand,
                  (i < 2000) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 299) == 0),
                  4'($urandom_range(0, 15)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
